// File: rtl/byte_lane_write_sched_pkg.sv
// Shared definitions for the byte-lane write scheduler and its arbiter.
package byte_lane_write_sched_pkg;

  localparam int BYTE_W = 8;

  // Staged lane indices are carried at this fixed width, so up to 256 lanes are supported.
  localparam int LANE_W_MAX = 8;

  // Ceiling log2 with a floor of 1, so a single-lane or two-requester build still has a usable index.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // One granted byte on its way to the output register.
  typedef struct packed {
    logic                  valid;
    logic [BYTE_W-1:0]     data;
    logic [LANE_W_MAX-1:0] lane;
  } stage_entry_t;

endpackage

// File: rtl/byte_lane_write_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector.
// The search starts at the pointer, and the pointer moves past the winner whenever a grant is issued.
module byte_lane_write_sched_rr_arbiter
  import byte_lane_write_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = clog2_min1(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Pick the first requester at or after the pointer. Nothing is granted while disabled or in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N);
      if (en_i && !reset && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PTR_W'((int'(idx) + 1) % N);
      end
    end
  end

  // Pointer register, which advances only when a grant is accepted.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples its pre-edge inputs.
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/byte_lane_write_sched.sv
// Byte-lane write scheduler. NREQ byte writers share one wide output register.
// Each cycle, one request is granted and staged for a cycle, then written into its byte lane.
module byte_lane_write_sched
  import byte_lane_write_sched_pkg::*;
#(
  parameter  int width  = 32,
  parameter  int NREQ   = 4,
  localparam int LANES  = width / BYTE_W,
  localparam int LANE_W = clog2_min1(LANES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  input  logic [NREQ*LANE_W-1:0] req_lane,
  input  logic                   hold,
  input  logic                   clear,
  output logic [width-1:0]       out,
  output logic                   out_update,
  output logic                   lane_err,
  output logic                   busy
);

  stage_entry_t     stage_q, stage_d;
  logic [width-1:0] out_q, out_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;

  byte_lane_write_sched_rr_arbiter #(.N(NREQ)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_i   (req_valid),
    .en_i    (~hold),
    .grant_o (req_ready)
  );

  // Capture the granted requester's byte and lane. With no grant, the stage empties.
  always_comb begin
    stage_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        stage_d.valid = 1'b1;
        stage_d.data  = req_data[i*BYTE_W +: BYTE_W];
        stage_d.lane  = LANE_W_MAX'(req_lane[i*LANE_W +: LANE_W]);
      end
    end
  end

  // Land the staged byte. Clear wins over a same-cycle write, and an out-of-range lane only flags an error.
  always_comb begin
    out_d = out_q;
    upd_d = 1'b0;
    err_d = err_q;
    if (clear) begin
      out_d = '0;
      upd_d = 1'b1;
    end else if (stage_q.valid) begin
      if (int'(stage_q.lane) < LANES) begin
        for (int l = 0; l < LANES; l++) begin
          if (int'(stage_q.lane) == l) out_d[l*BYTE_W +: BYTE_W] = stage_q.data;
        end
        upd_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Stage and output registers. Reset drops any staged entry and zeroes the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
      out_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign out        = out_q;
  assign out_update = upd_q;
  assign lane_err   = err_q;
  assign busy       = stage_q.valid;

endmodule

// File: doc/byte_lane_write_sched.md
Name: byte_lane_write_sched

Overview:
- Round-robin scheduler that shares one wide output register between NREQ byte-writers.
- Each requester supplies one byte and a lane index. One request is granted per cycle, staged for one cycle, then written into out[lane*8 +: 8].
- Sits between byte-producing datapath stages and a wide result/status register; replaces ad-hoc multi-driver part-select writes.

Parameters:
width, 32, output register width in bits; must be a multiple of 8
NREQ, 4, number of requesters (>=2)
LANES, width/8, number of byte lanes (derived; localparam)
LANE_W, clog2(LANES) min 1, lane index width (derived; localparam)

Ports:
clock  input  1  clock, rising edge
reset  input  1  synchronous, active-high
req_valid  input  NREQ  per-requester request
req_ready  output  NREQ  per-requester grant (combinational)
req_data  input  NREQ*8  byte for requester i at [i*8 +: 8]
req_lane  input  NREQ*LANE_W  lane for requester i at [i*LANE_W +: LANE_W]
hold  input  1  1 = issue no new grants; pipeline still drains
clear  input  1  zero the whole output register
out  output  width  assembled register
out_update  output  1  1-cycle pulse after any lane write lands
lane_err  output  1  sticky; set when a granted lane >= LANES
busy  output  1  stage register holds a valid entry

Behaviour:
- Reset is synchronous and active-high on clock.
- Reset values: out=0, out_update=0, lane_err=0, busy=0, stage valid=0, rr pointer=0. Reset mid-operation discards the staged entry.
- Arbitration: search starts at pointer p and runs p, p+1, … mod NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - At most one ready bit is high per cycle.
  - ready is combinational from req_valid, p and hold, and is 0 while hold=1 or reset=1.
- A handshake is req_valid[i] & req_ready[i]. At that edge: pointer := (i+1) mod NREQ; stage := {valid=1, data, lane}.
- With no handshake the pointer is unchanged and stage valid := 0.
- No backpressure from out, so the scheduler can grant every cycle.
- Write stage: at the edge after capture, if stage valid:
  - lane < LANES: out[lane*8 +: 8] := data, and out_update := 1 for the following cycle.
  - lane >= LANES: out unchanged, out_update := 0, lane_err := 1 (sticky until reset).
- Latency: handshake at edge E, out updated at edge E+1, out_update high during the cycle after E+1. Throughput is 1 byte/cycle.
- clear=1 at an edge: out := 0 and out_update := 1.
  - clear has priority over a same-edge stage write; that write is dropped (no lane_err update).
  - Staging and granting continue during clear.
- Back-to-back writes to the same lane apply in grant order; the last one wins.
- hold asserted: entry already in stage still writes; no new grants; pointer frozen.
- busy = stage valid.
- Lanes not written since reset/clear keep 0.

Decomposition:
- Shared package: the byte width constant (8), the clog2 function, and a stage-entry typedef {valid, data[7:0], lane[LANE_W-1:0]}.
- One sub-module is natural: rr_arbiter (NREQ one-hot request -> one-hot grant with pointer update on accept). It is reusable by other schedulers.
- Stage register and lane write stay in the top module.

Test Plan:
- Reset then idle: out=0, out_update=0, busy=0, all ready=0. Hold reset for 3 cycles mid-traffic: staged entry dropped, out=0.
- Single writer: req0 valid, lane 2, data 0xAB. ready0 same cycle; out=0x00AB0000 at E+1; out_update pulses once.
- All 4 valid continuously, lanes 0..3, data 0x11/0x22/0x33/0x44. Grants are 0,1,2,3,0,… one per cycle; out=0x44332211 after 5 edges.
- Same-lane conflict: req1 and req3 both lane 0, data 0x5A and 0xA5, pointer at 1. Grant order 1 then 3; final out[7:0]=0xA5.
- clear coincident with a staged write of 0xFF to lane 1 (out previously 0x12345678). Result: out=0, lane 1 stays 0x00, out_update=1.
- Override width=40 (LANES=5, LANE_W=3); issue lane 6. out unchanged, lane_err=1 and stays 1; a following valid lane 4 write of 0x9C lands in out[39:32]. Also: hold=1 with valid requests gives no ready, and the staged entry still lands.
